// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Owner encoding tracks which access the memory answers in the following cycle.
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view,
// master is the surrounding environment (fetch unit, load/store unit, memory).
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          igrant;
  logic          ivalid;
  logic [DW-1:0] irdata;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dgrant;
  logic          dvalid;
  logic [DW-1:0] drdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rd,
    output igrant, ivalid, irdata, dgrant, dvalid, drdata,
           mem_en, mem_we, mem_addr, mem_wd
  );

  modport master (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rd,
    input  igrant, ivalid, irdata, dgrant, dvalid, drdata,
           mem_en, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the instruction side waits while requesting; saturates
// at STARVE_MAX, and at_max forces the next instruction grant.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq,
  input  logic igrant,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ireq || igrant) begin
      cnt_d = '0;
    end else if (cnt_q != STARVE_W'(STARVE_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous memory: data side has
// priority, instruction side is forced through after STARVE_MAX denied cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  owner_e        owner_q, owner_d;
  logic          at_max;
  logic          i_win, d_win;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wd_d;

  // Grants are qualified by reset so nothing reaches the memory while held in reset.
  always_comb begin
    i_win   = reset & bus.ireq & (~bus.dreq | at_max);
    d_win   = reset & bus.dreq & ~i_win;
    we_d    = 1'b0;
    addr_d  = '0;
    wd_d    = '0;
    owner_d = NONE;
    if (i_win) begin
      addr_d  = bus.iaddr;
      owner_d = IRD;
    end else if (d_win) begin
      we_d    = bus.dwe;
      addr_d  = bus.daddr;
      wd_d    = bus.dwdata;
      owner_d = bus.dwe ? DWR : DRD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .ireq   (bus.ireq),
    .igrant (i_win),
    .at_max (at_max)
  );

  assign bus.igrant   = i_win;
  assign bus.dgrant   = d_win;
  assign bus.mem_en   = i_win | d_win;
  assign bus.mem_we   = we_d;
  assign bus.mem_addr = addr_d;
  assign bus.mem_wd   = wd_d;

  // Responses are a pure decode of who owned the previous memory cycle.
  assign bus.ivalid = (owner_q == IRD);
  assign bus.dvalid = (owner_q == DRD) || (owner_q == DWR);
  assign bus.irdata = (owner_q == IRD) ? bus.mem_rd : '0;
  assign bus.drdata = (owner_q == DRD) ? bus.mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [31:0] mem [0:1023];

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wd;
      else            bus.mem_rd <= mem[bus.mem_addr[11:2]];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.ireq   = 1'b0;
    bus.iaddr  = '0;
    bus.dreq   = 1'b0;
    bus.dwe    = 1'b0;
    bus.daddr  = '0;
    bus.dwdata = '0;
  endtask

  task automatic test_reset();
    next_cycle();
    bus.ireq  = 1'b1;
    bus.dreq  = 1'b1;
    bus.dwe   = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.igrant, bus.dgrant} !== 2'b00) begin n_err++; $display("FAIL reset_grants got=%b exp=00", {bus.igrant, bus.dgrant}); end
    n_vec++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin n_err++; $display("FAIL reset_mem got=%b exp=00", {bus.mem_en, bus.mem_we}); end
    n_vec++; if ({bus.ivalid, bus.dvalid} !== 2'b00) begin n_err++; $display("FAIL reset_valid got=%b exp=00", {bus.ivalid, bus.dvalid}); end
    n_vec++; if (bus.irdata !== 32'h0 || bus.drdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.irdata, bus.drdata); end
    n_vec++; if (dut.u_starve.cnt_q !== 4'd0) begin n_err++; $display("FAIL reset_starve got=%0d exp=0", dut.u_starve.cnt_q); end
    // First grant in the very first cycle after release.
    next_cycle();
    clear_reqs();
    rst_n     = 1'b1;
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h8;
    @(negedge clk);
    n_vec++; if ({bus.igrant, bus.dgrant, bus.mem_en} !== 3'b101) begin n_err++; $display("FAIL first_grant got=%b exp=101", {bus.igrant, bus.dgrant, bus.mem_en}); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_ifetch();
    mem[10'h040] = 32'hDEADBEEF;
    next_cycle();
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h100;
    @(negedge clk);
    n_vec++; if ({bus.igrant, bus.dgrant} !== 2'b10) begin n_err++; $display("FAIL ifetch_grant got=%b exp=10", {bus.igrant, bus.dgrant}); end
    n_vec++; if ({bus.mem_en, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h100 || bus.mem_wd !== 32'h0) begin n_err++; $display("FAIL ifetch_mem got=%b a=%h wd=%h exp=10 a=100 wd=0", {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wd); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_vec++; if ({bus.ivalid, bus.dvalid} !== 2'b10) begin n_err++; $display("FAIL ifetch_valid got=%b exp=10", {bus.ivalid, bus.dvalid}); end
    n_vec++; if (bus.irdata !== 32'hDEADBEEF || bus.drdata !== 32'h0) begin n_err++; $display("FAIL ifetch_data got=%h/%h exp=deadbeef/0", bus.irdata, bus.drdata); end
    next_cycle();
    @(negedge clk);
    n_vec++; if ({bus.ivalid, bus.irdata} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL ifetch_pulse got=%b/%h exp=0/0", bus.ivalid, bus.irdata); end
  endtask

  task automatic test_write_read();
    next_cycle();
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 32'h40;
    bus.dwdata = 32'h12345678;
    @(negedge clk);
    n_vec++; if ({bus.dgrant, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_wd !== 32'h12345678 || bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL wr_issue got=%b a=%h wd=%h exp=111 a=40 wd=12345678", {bus.dgrant, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wd); end
    next_cycle();
    bus.dwe    = 1'b0;
    bus.dwdata = '0;
    @(negedge clk);
    n_vec++; if ({bus.dvalid, bus.ivalid} !== 2'b10 || bus.drdata !== 32'h0) begin n_err++; $display("FAIL wr_ack got=%b d=%h exp=10 d=0", {bus.dvalid, bus.ivalid}, bus.drdata); end
    n_vec++; if ({bus.dgrant, bus.mem_en, bus.mem_we} !== 3'b110) begin n_err++; $display("FAIL rd_issue got=%b exp=110", {bus.dgrant, bus.mem_en, bus.mem_we}); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_vec++; if (bus.dvalid !== 1'b1 || bus.drdata !== 32'h12345678) begin n_err++; $display("FAIL rd_data got=%b/%h exp=1/12345678", bus.dvalid, bus.drdata); end
  endtask

  task automatic test_contention();
    logic exp_i, exp_iv;
    next_cycle();
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h4;
    bus.dreq  = 1'b1;
    bus.daddr = 32'h0;
    for (int k = 0; k < 15; k++) begin
      exp_i  = ((k % 5) == 4);
      exp_iv = (k > 0) && (((k - 1) % 5) == 4);
      @(negedge clk);
      n_vec++; if ({bus.igrant, bus.dgrant} !== {exp_i, ~exp_i}) begin n_err++; $display("FAIL contend_grant k=%0d got=%b exp=%b", k, {bus.igrant, bus.dgrant}, {exp_i, ~exp_i}); end
      n_vec++; if (bus.ivalid !== exp_iv || bus.dvalid !== (k > 0 && !exp_iv)) begin n_err++; $display("FAIL contend_valid k=%0d got=%b%b exp=%b%b", k, bus.ivalid, bus.dvalid, exp_iv, (k > 0 && !exp_iv)); end
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    mem[10'h000] = 32'hA5A50000;
    mem[10'h001] = 32'h00005A5A;
    next_cycle();
    bus.dreq  = 1'b1;
    bus.daddr = 32'h0;
    @(negedge clk);
    n_vec++; if ({bus.dgrant, bus.igrant} !== 2'b10) begin n_err++; $display("FAIL b2b_dgrant got=%b exp=10", {bus.dgrant, bus.igrant}); end
    next_cycle();
    clear_reqs();
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h4;
    @(negedge clk);
    n_vec++; if ({bus.igrant, bus.mem_en, bus.dvalid} !== 3'b111 || bus.mem_addr !== 32'h4) begin n_err++; $display("FAIL b2b_overlap got=%b a=%h exp=111 a=4", {bus.igrant, bus.mem_en, bus.dvalid}, bus.mem_addr); end
    n_vec++; if (bus.drdata !== 32'hA5A50000) begin n_err++; $display("FAIL b2b_ddata got=%h exp=a5a50000", bus.drdata); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_vec++; if ({bus.ivalid, bus.dvalid} !== 2'b10 || bus.irdata !== 32'h00005A5A || bus.drdata !== 32'h0) begin n_err++; $display("FAIL b2b_idata got=%b %h/%h exp=10 00005a5a/0", {bus.ivalid, bus.dvalid}, bus.irdata, bus.drdata); end
  endtask

  task automatic test_reset_in_flight();
    next_cycle();
    bus.dreq  = 1'b1;
    bus.daddr = 32'h40;
    @(negedge clk);
    n_vec++; if (bus.dgrant !== 1'b1) begin n_err++; $display("FAIL rif_grant got=%b exp=1", bus.dgrant); end
    #1;
    rst_n    = 1'b0;
    clear_reqs();
    bus.ireq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if ({bus.dvalid, bus.ivalid, bus.igrant, bus.dgrant, bus.mem_en, bus.mem_we} !== 6'b0 || bus.drdata !== 32'h0 || bus.irdata !== 32'h0) begin n_err++; $display("FAIL rif_held k=%0d got=%b %h/%h exp=000000 0/0", k, {bus.dvalid, bus.ivalid, bus.igrant, bus.dgrant, bus.mem_en, bus.mem_we}, bus.drdata, bus.irdata); end
    end
    next_cycle();
    clear_reqs();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++; if ({bus.dvalid, bus.ivalid} !== 2'b00) begin n_err++; $display("FAIL rif_release k=%0d got=%b exp=00", k, {bus.dvalid, bus.ivalid}); end
    end
  endtask

  task automatic test_idle();
    next_cycle();
    clear_reqs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++; if (bus.mem_en !== 1'b0 || dut.u_starve.cnt_q !== 4'd0) begin n_err++; $display("FAIL idle k=%0d mem_en=%b starve=%0d exp=0/0", k, bus.mem_en, dut.u_starve.cnt_q); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mem_rd = '0;
    clear_reqs();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_ifetch();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_in_flight();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width in bits.
REQ-002 Parameter DW, default 32: data width in bits.
REQ-003 Parameter STARVE_MAX, default 4: maximum number of consecutive cycles the instruction requester may be denied before it is forcibly granted; legal range 1..15.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port ireq, input, 1: instruction-fetch read request.
REQ-007 Port iaddr, input, AW: instruction fetch address.
REQ-008 Port igrant, output, 1: instruction request accepted this cycle (combinational).
REQ-009 Port ivalid, output, 1: instruction read data valid (registered pulse).
REQ-010 Port irdata, output, DW: instruction read data.
REQ-011 Port dreq, input, 1: data-side request.
REQ-012 Port dwe, input, 1: data-side write enable; 1 = write, 0 = read.
REQ-013 Port daddr, input, AW: data address.
REQ-014 Port dwdata, input, DW: data write value.
REQ-015 Port dgrant, output, 1: data request accepted this cycle (combinational).
REQ-016 Port dvalid, output, 1: data read data valid, or write acknowledge (registered pulse).
REQ-017 Port drdata, output, DW: data read data.
REQ-018 Port mem_en, output, 1: strobe to the shared single-port synchronous memory.
REQ-019 Port mem_we, output, 1: memory write enable.
REQ-020 Port mem_addr, output, AW: memory address.
REQ-021 Port mem_wd, output, DW: memory write data.
REQ-022 Port mem_rd, input, DW: memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-023 Handshake: a requester holds its request and request fields stable until it sees its grant; the request is consumed in the cycle its grant is high.
REQ-024 At most one grant per cycle; igrant and dgrant are never both 1.
REQ-025 Arbitration: the data side wins when both request, unless starve_cnt==STARVE_MAX, in which case the instruction side wins.
REQ-026 A single requester is granted in the same cycle it requests (zero-cycle grant latency).
REQ-027 On a grant, mem_en=1 and mem_addr/mem_we/mem_wd are driven from the winner in that cycle; on an instruction grant, mem_we=0 and mem_wd=0; with no grant, mem_en=0 and mem_we=0.
REQ-028 Owner state machine with states NONE, IRD, DRD, DWR: the next state is IRD on an instruction grant, DRD on a data read grant, DWR on a data write grant, and NONE otherwise.
REQ-029 ivalid=1 exactly in the cycle owner==IRD; dvalid=1 exactly in the cycles owner==DRD or owner==DWR.
REQ-030 irdata=mem_rd when owner==IRD, else 0; drdata=mem_rd when owner==DRD, else 0.
REQ-031 Throughput is one access per cycle: a new grant may issue in the same cycle a previous response is returned (back-to-back operation).
REQ-032 starve_cnt (4-bit): increments when ireq & ~igrant and saturates at STARVE_MAX; cleared when igrant=1 or ireq=0.
REQ-033 A starvation-forced instruction grant clears starve_cnt, and data priority resumes on the next cycle.

Reset
REQ-034 While reset=0: owner=NONE, starve_cnt=0, ivalid=0, dvalid=0, irdata=0, drdata=0, igrant=0, dgrant=0, mem_en=0, mem_we=0.
REQ-035 Reset asserted mid-access drops any in-flight response, and no valid pulse appears after reset is released.
REQ-036 The first grant is possible in the first rising edge cycle after reset is released.

Structure
REQ-037 Package mem_arb_pkg holds the owner_e enum (NONE, IRD, DRD, DWR) and the STARVE_W=4 localparam.
REQ-038 The starvation counter is a sub-module, mem_arb_starve_ctr (inputs ireq, igrant; output at_max).
REQ-039 The arbiter priority logic is combinational; only owner and starve_cnt are registered, and ivalid/dvalid decode from owner.

Verification
REQ-040 Instruction only: ireq=1, iaddr=0x100 with memory[0x100]=0xDEADBEEF -> igrant=1 in cycle 0; ivalid=1, irdata=0xDEADBEEF in cycle 1.
REQ-041 Data write then read: dwe=1, daddr=0x40, dwdata=0x12345678, then dwe=0 at 0x40 -> dvalid in cycles 1 and 2; drdata=0x12345678 in cycle 2.
REQ-042 Contention: ireq=1 and dreq=1 held continuously, STARVE_MAX=4 -> four dgrants, then one igrant, repeating every 5 cycles; never both grants in one cycle.
REQ-043 Back-to-back reads: D read 0x0, then I read 0x4 in consecutive cycles -> dvalid in cycle 1 and ivalid in cycle 2, each carrying the correct data.
REQ-044 Reset in flight: a data read is granted, then reset=0 in the next cycle before the edge -> dvalid stays 0, and all outputs are at reset values until reset is released.
REQ-045 Idle: no requests for 10 cycles -> mem_en=0 and starve_cnt=0 throughout.
